// File: rtl/combi_pkg.sv
// Shared types for the combined ARM/RISC-V decode mode tracker.
package combi_pkg;

    typedef enum logic {
        ISA_RV  = 1'b0,
        ISA_ARM = 1'b1
    } isa_t;

    // Bit 1 of the encoding is the committed ISA; bit 0 marks a run in progress.
    typedef enum logic [1:0] {
        RV_STEADY  = 2'b00,
        RV_PEND    = 2'b01,
        ARM_STEADY = 2'b10,
        ARM_PEND   = 2'b11
    } mode_state_t;

    function automatic mode_state_t steady_of(input logic isa);
        return isa ? ARM_STEADY : RV_STEADY;
    endfunction

    function automatic mode_state_t pend_of(input logic isa);
        return isa ? ARM_PEND : RV_PEND;
    endfunction

    function automatic logic isa_of(input mode_state_t s);
        return (s == ARM_STEADY) || (s == ARM_PEND);
    endfunction

endpackage

// File: rtl/combi_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module combi_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/combi_mode_tracker.sv
// ISA-mode arbiter for the combined ARM/RISC-V decode stage: hysteretic
// mode switching on runs of other-ISA-only instructions, plus forced sets.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   RV_STEADY  | committed RISC-V, no other-ISA run in progress (cnt = 0)
//   RV_PEND    | committed RISC-V, cnt ARM-only instructions seen in a row
//   ARM_STEADY | committed ARM, no other-ISA run in progress (cnt = 0)
//   ARM_PEND   | committed ARM, cnt RISC-V-only instructions seen in a row
module combi_mode_tracker
    import combi_pkg::*;
#(
    parameter int SWITCH_THRESH = 2,
    parameter bit RESET_MODE    = 1'b0,
    parameter int STAT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flushD,
    input  logic              rv_valid,
    input  logic              arm_valid,
    input  logic              force_valid,
    input  logic              force_mode,
    output logic              armD,
    output logic              mode_q,
    output logic              illegal_o,
    output logic              switch_o,
    output logic              pending_o,
    output logic [STAT_W-1:0] switch_cnt,
    output logic [STAT_W-1:0] illegal_cnt
);

    localparam int CW  = $clog2(SWITCH_THRESH + 1);
    localparam int CW1 = CW + 1;

    generate
        if (SWITCH_THRESH < 1 || SWITCH_THRESH > 255) begin : g_bad_thresh
            $error("combi_mode_tracker: SWITCH_THRESH must be in 1..255");
        end
    endgenerate

    mode_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          switch_d;
    logic          cur_isa;
    logic          own_valid;
    logic          other_only;
    logic          accept;
    logic          illegal_d;
    logic [CW:0]   cnt_inc;

    assign cur_isa    = isa_of(state_q);
    assign own_valid  = cur_isa ? arm_valid : rv_valid;
    assign other_only = ~own_valid & (cur_isa ? rv_valid : arm_valid);
    assign accept     = en & ~flushD;
    assign cnt_inc    = {1'b0, cnt_q} + CW1'(1);
    // A same-cycle force discards the instruction's update, including its illegal event.
    assign illegal_d  = accept & ~force_valid & ~rv_valid & ~arm_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= steady_of(RESET_MODE);
            cnt_q    <= '0;
            switch_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            switch_o <= switch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        switch_d = 1'b0;
        if (force_valid) begin
            state_d  = steady_of(force_mode);
            cnt_d    = '0;
            switch_d = (force_mode != cur_isa);
        end else if (accept) begin
            if (own_valid) begin
                state_d = steady_of(cur_isa);
                cnt_d   = '0;
            end else if (other_only) begin
                if (cnt_inc == CW1'(SWITCH_THRESH)) begin
                    state_d  = steady_of(~cur_isa);
                    cnt_d    = '0;
                    switch_d = 1'b1;
                end else begin
                    state_d = pend_of(cur_isa);
                    cnt_d   = cnt_inc[CW-1:0];
                end
            end else begin
                state_d = steady_of(cur_isa);
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        mode_q    = cur_isa;
        pending_o = (cnt_q != '0);
        illegal_o = illegal_d;
        armD      = cur_isa;
        if (!flushD && other_only) begin
            armD = ~cur_isa;
        end
    end

    combi_sat_counter #(.W(STAT_W)) u_switch_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (switch_d),
        .cnt   (switch_cnt)
    );

    combi_sat_counter #(.W(STAT_W)) u_illegal_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (illegal_d),
        .cnt   (illegal_cnt)
    );

endmodule
